serial_adder: RTL and testbench

Bit-serial N-bit adder. Operands are processed LSB-first, one bit per clock, through a single one-bit full-adder cell and a registered carry. It is the additive counterpart of the team's full-subtractor lab cell and replaces a ripple-carry adder where area matters more than latency. It uses a start/busy/done handshake for a simple upstream controller.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_if.sv | 38 +++
 rtl/serial_adder_full_adder_bit.sv | 16 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE, SHIFT, FIN)
//   SA_WIDTH_DEF  : default operand width
//   cnt_width()   : width of the bit counter for a given operand width
// Optional feature macro used by the files of this block: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int SA_WIDTH_DEF = 8;

  // The counter runs 0..w-1, so clog2(w) bits suffice; guard against w<2.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Bus between an upstream controller (master) and the serial adder (slave).
//   start, a, b, cin [, sub] : request and operands, master -> slave
//   busy, done, s, cout      : status and result, slave -> master
//   dbg_state                : current FSM state, for observation only
// Macro SERIAL_ADDER_SUB_EN adds the sub request bit.
//
// Handshake: start is sampled on a rising edge only while busy is low
// (IDLE or FIN); that edge captures a/b/cin[/sub]. done pulses for exactly one
// cycle when s/cout become valid; s/cout then hold until the next result.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::SA_WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  serial_adder_pkg::state_t dbg_state;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub,
                  input  busy, done, s, cout, dbg_state);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, s, cout, dbg_state);
`else
  modport master (output start, a, b, cin,
                  input  busy, done, s, cout, dbg_state);
  modport slave  (input  start, a, b, cin,
                  output busy, done, s, cout, dbg_state);
`endif

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder cell used as the serial datapath.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out (majority of the inputs)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock through a single
// full-adder cell with a registered carry. One result per WIDTH+1 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_adder_if slave (start/a/b/cin[/sub] in,
//                busy/done/s/cout/dbg_state out)
// Macro SERIAL_ADDER_SUB_EN: sub=1 computes a-b (b inverted, carry-in forced
// to 1); cout=1 then means no borrow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;      // sums so far; the final bit is appended at FIN entry
  logic             c;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .s    (sum_bit),
    .cout (carry_next)
  );

  assign res_next = {sum_bit, res};

  // Operand B and carry seen at load time; subtraction is a + ~b + 1.
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, FIN: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= b_load;
            c      <= c_load;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          c    <= carry_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_next[WIDTH-1:1];
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // Results become visible only here, never mid-shift.
            s_q    <= res_next;
            cout_q <= carry_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Directed cases plus random
// operations checked against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {cout, s} from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sb);
    longint unsigned av;
    longint unsigned bv;
    longint unsigned m;
    av = a;
    bv = b;
    m  = 64'd1 << W;
    if (sb) return {(av >= bv), W'((av + m - bv) % m)};
    return (W+1)'(av + bv + longint'(ci));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sb;
`else
    if (sb) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Called #1 after the accepting edge. lat counts cycles from that edge to
  // the done cycle inclusive. At lat==pulse_at a stray start is raised.
  task automatic wait_done(input int pulse_at, output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (!bus.done && lat <= 4 * W) begin
      if (bus.busy) busy_cyc++;
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic sb, input int lat, input int bc);
    logic [W:0] exp;
    exp = model(a, b, ci, sb);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_s"}, 32'(bus.s), 32'(exp[W-1:0]));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(exp[W]));
    chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
    chk({tag, "_busycyc"}, 32'(bc), 32'(W));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb);
    int lat;
    int bc;
    logic [W:0] exp;
    exp = model(a, b, ci, sb);
    drive(a, b, ci, sb);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, lat, bc);
    check_result(tag, a, b, ci, sb, lat, bc);
    // done is a single pulse; the result holds afterwards.
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_s_hold"}, 32'(bus.s), 32'(exp[W-1:0]));
  endtask

  initial begin
    int lat;
    int bc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic rs;
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_done", 32'(bus.done), 32'd0);

    // Directed arithmetic
    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start while busy is ignored
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(3, lat, bc);
    check_result("ignore", 8'h10, 8'h20, 1'b0, 1'b0, lat, bc);

    // Back-to-back: start held into FIN with new operands
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, lat, bc);
    check_result("b2b_first", 8'h11, 8'h22, 1'b0, 1'b0, lat, bc);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy_after_fin", 32'(bus.busy), 32'd1);
    chk("b2b_s_hold_in_shift", 32'(bus.s), 32'h33);
    wait_done(0, lat, bc);
    check_result("b2b_second", 8'h01, 8'h01, 1'b0, 1'b0, lat, bc);

    // Reset during SHIFT cycle 4
    drive(8'h12, 8'h34, 1'b1, 1'b0);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_s", 32'(bus.s), 32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_done", 32'(bus.done), 32'd0);
    end
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
    run_op("sub_09_03", 8'h09, 8'h03, 1'b0, 1'b1);
`endif

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op("rand", ra, rb, rc, rs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
